// File: rtl/jt49_dcrm_sched.sv
// jt49_dcrm_sched: time-multiplexed DC removal for the three PSG channels
//   clk, rst        clock, synchronous active-high reset
//   cen             sample strobe; latches din_a/b/c and chen when idle
//   din_a/b/c       unsigned channel levels
//   chen            per-channel enable (bit0=A, bit1=B, bit2=C)
//   clr_ovr         clears the sticky overrun flag
//   dout_a/b/c      signed DC-removed samples
//   dout_valid      pulse when all three outputs hold the new sample
//   busy            high while slot A, B or C is being processed
//   overrun         sticky; set when a cen arrives while busy
module jt49_dcrm_sched #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] din_a,
    input  logic [7:0] din_b,
    input  logic [7:0] din_c,
    input  logic [2:0] chen,
    input  logic       clr_ovr,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b,
    output logic [7:0] dout_c,
    output logic       dout_valid,
    output logic       busy,
    output logic       overrun
);
    typedef enum logic [1:0] {IDLE, SA, SB, SC} state_t;
    state_t st, st_nx;
    logic [7:0] s_a, s_b, s_c, s, dc, sat;
    logic [2:0] en;
    logic sen;
    logic [W+7:0] acc_a, acc_b, acc_c, acc, acc_nx;
    logic signed [8:0] diff;
    always_comb begin
        st_nx = IDLE;
        case (st)
            IDLE: st_nx = cen ? SA : IDLE;
            SA:   st_nx = SB;
            SB:   st_nx = SC;
            default: st_nx = IDLE;
        endcase
    end
    // shared datapath: pick the channel owned by the current slot
    assign acc  = st == SB ? acc_b : st == SC ? acc_c : acc_a;
    assign s    = st == SB ? s_b : st == SC ? s_c : s_a;
    assign sen  = st == SB ? en[1] : st == SC ? en[2] : en[0];
    assign dc   = acc[W+7:W];
    assign diff = $signed({1'b0, s}) - $signed({1'b0, dc});
    assign sat  = diff > 9'sd127 ? 8'h7f : diff < -9'sd128 ? 8'h80 : diff[7:0];
    // leaky integrator; bounded by 255*2^W so it never wraps
    assign acc_nx = acc - (acc >> W) + {{W{1'b0}}, s};
    assign busy = st != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            {s_a, s_b, s_c, en} <= '0;
            {acc_a, acc_b, acc_c} <= '0;
            {dout_a, dout_b, dout_c} <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            st         <= st_nx;
            dout_valid <= st == SC;
            overrun    <= (cen && st != IDLE) || (overrun && !clr_ovr);
            if (cen && st == IDLE) {s_a, s_b, s_c, en} <= {din_a, din_b, din_c, chen};
            if (st == SA) begin
                dout_a <= sen ? sat : 8'h00;
                if (sen) acc_a <= acc_nx;
            end
            if (st == SB) begin
                dout_b <= sen ? sat : 8'h00;
                if (sen) acc_b <= acc_nx;
            end
            if (st == SC) begin
                dout_c <= sen ? sat : 8'h00;
                if (sen) acc_c <= acc_nx;
            end
        end
    end
endmodule

// File: doc/jt49_dcrm_sched.md
# jt49_dcrm_sched

Time-multiplexed DC-removal scheduler for the three PSG tone channels. One sample strobe latches all three unsigned channel levels. A single shared leaky-integrator datapath then processes them in three consecutive slots (A, B, C), each against that channel's private DC accumulator. The block sits between the jt49 channel mixers and the output mixer, replacing three independent DC-removal filters with one arithmetic unit and a small state file.

## Interface

Parameters:
- W, 8, integrator shift; DC time constant is about 2^W samples; accumulator width is 8+W bits

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- cen  input  1  sample strobe; one-cycle pulse
- din_a, din_b, din_c  input  8  unsigned channel levels, sampled on accepted cen
- chen  input  3  per-channel enable, bit0=A, bit1=B, bit2=C; sampled on accepted cen
- clr_ovr  input  1  clears the overrun flag
- dout_a, dout_b, dout_c  output  8  signed DC-removed samples
- dout_valid  output  1  one-cycle pulse when all three outputs hold the new sample
- busy  output  1  high while a slot is in progress
- overrun  output  1  sticky; set when cen is dropped

## Operation

- FSM states: IDLE, SA, SB, SC.
  - IDLE → SA on cen. On that edge, din_* and chen are latched into snapshot registers.
  - SA → SB → SC → IDLE unconditionally, one cycle each.
- busy = 1 in SA, SB and SC; busy = 0 in IDLE.
- Per-slot datapath for channel x, using snapshot value s and accumulator acc_x (8+W bits, unsigned):
  - dc = acc_x[W+7:W], taken before update.
  - diff = {1'b0,s} − {1'b0,dc}, 9-bit signed, range −255..255.
  - dout_x ← diff saturated to −128..127.
  - acc_x ← acc_x − (acc_x >> W) + s. This cannot overflow: acc_x ≤ 255·2^W holds by induction.
- Disabled channel (snapshot chen bit = 0):
  - The slot is still consumed, so latency stays fixed.
  - acc_x is held.
  - dout_x ← 0.
- cen while busy:
  - The sample is dropped, snapshot and accumulators are untouched, and overrun ← 1.
- clr_ovr = 1 clears overrun.
  - If clr_ovr and a dropped cen occur in the same cycle, set wins and overrun stays 1.
- cen in IDLE in the same cycle as dout_valid is accepted normally.
- Reset values:
  - FSM = IDLE.
  - All acc_x = 0.
  - dout_a/b/c = 0, dout_valid = 0, busy = 0, overrun = 0.
  - Snapshot registers = 0.
- Reset asserted mid-sequence: return to IDLE on the next edge with all state cleared. No dout_valid is produced for the aborted sample.

## Timing

- cen high in cycle T (FSM in IDLE): snapshot is loaded at the edge ending T.
- SA occupies T+1; dout_a and acc_a update at the edge ending T+1.
- SB occupies T+2 (updates dout_b, acc_b); SC occupies T+3 (updates dout_c, acc_c).
- dout_valid is high during T+4 (FSM back in IDLE). Latency from cen to dout_valid is 4 cycles.
- Maximum accepted sample rate is one cen per 4 clk cycles. A cen in T+1..T+3 is dropped.
- dout_a becomes new at T+2 and dout_b at T+3, ahead of dout_valid. Consumers sample all three outputs only on dout_valid.
- overrun becomes visible in the cycle after the dropped cen.

## Test plan

- Reset check: hold rst for 3 cycles, then release.
  - Required: all outputs 0, busy 0.
  - First cen gives busy high for exactly 3 cycles and dout_valid exactly 4 cycles after cen.
- Convergence: din_a = din_b = din_c = 100, chen = 3'b111, cen every 8 cycles, W=8.
  - First sample: dout_* = +100.
  - Output decreases monotonically.
  - After 4096 samples: dout_* = 0 and acc_* ≥ 25600. After that, dout_* stays 0.
- Saturation: after 64 samples of din = 0 (acc = 0), apply din_a = 255 → dout_a = +127.
  - Then converge with din_a = 255 for 8192 samples (dc = 255). Apply din_a = 0 → dout_a = −128.
- Channel disable: converge all channels at 100, then one sample with chen = 3'b101 and din_b = 200.
  - Required: dout_b = 0, acc_b unchanged, next enabled sample of din_b = 100 gives dout_b = 0.
  - dout_valid timing is unchanged.
- Overrun:
  - cen at T and T+2: the second sample is dropped, overrun = 1 from T+3, one dout_valid only.
  - clr_ovr alone clears overrun.
  - clr_ovr together with a dropped cen leaves overrun = 1.
  - cen at T and T+4: both accepted, overrun stays 0.
- Reset mid-operation: assert rst during SB.
  - Required: no dout_valid, outputs 0, next sample behaves like the first after reset (dout = din as a signed value, saturated).
